// File: rtl/disp_conf_writer.sv
// disp_conf_writer: pops {disp, conf} words from a show-ahead FIFO, applies a
// confidence threshold, and writes one 16-bit pixel per word into a raster
// frame buffer over an Avalon-MM write master. Signals completion of a
// dec_frame_width x dec_frame_height frame with a one-cycle frame_done pulse.
//
// state  | meaning
// IDLE   | no frame armed; upstream words are left in the FIFO
// ACCEPT | waiting for the next word; in_ready asserted
// WRITE  | one pixel held on the Avalon bus until waitrequest drops
module disp_conf_writer #(
  parameter int disp_bits        = 5,
  parameter int dec_frame_width  = 240,
  parameter int dec_frame_height = 135
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [disp_bits+7:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [7:0]           conf_threshold,
  output logic [31:0]          avm_address,
  output logic                 avm_write,
  output logic [15:0]          avm_writedata,
  input  logic                 avm_waitrequest,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(dec_frame_width + 1);
  localparam int RW = $clog2(dec_frame_height + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(dec_frame_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(dec_frame_height - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_thr;
  logic [31:0]     r_next_addr;
  logic [31:0]     r_avm_address;
  logic [15:0]     r_avm_writedata;
  logic            r_frame_done;

  logic            w_last;
  logic            w_ready;
  logic            w_xfer;
  logic [7:0]      w_conf;
  logic [disp_bits-1:0] w_disp;
  logic [15:0]     w_pix;

  assign w_last  = (r_col == COL_LAST) && (r_row == ROW_LAST);
  // A new word may be taken while the current write completes, except on the
  // last pixel, so at most one word is ever held inside the block.
  assign w_ready = (r_state == ACCEPT) ||
                   ((r_state == WRITE) && !avm_waitrequest && !w_last);
  assign w_xfer  = in_valid && w_ready;

  // Pixel formatting: low-confidence pixels get disparity forced to zero.
  always_comb begin
    w_conf = in_data[7:0];
    w_disp = in_data[disp_bits+7:8];
    w_pix  = '0;
    w_pix[15:8] = w_conf;
    if (w_conf >= r_thr)
      w_pix[disp_bits-1:0] = w_disp;
  end

  // Frame sequencing FSM with address, column/row tracking and write registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_col           <= '0;
      r_row           <= '0;
      r_thr           <= '0;
      r_next_addr     <= '0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
      r_frame_done    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_thr       <= conf_threshold;
            r_col       <= '0;
            r_row       <= '0;
            r_next_addr <= base_addr;
            r_state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (w_xfer) begin
            r_avm_address   <= r_next_addr;
            r_avm_writedata <= w_pix;
            r_next_addr     <= r_next_addr + 32'd2;
            r_state         <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_state      <= IDLE;
            end else begin
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
              if (w_xfer) begin
                r_avm_address   <= r_next_addr;
                r_avm_writedata <= w_pix;
                r_next_addr     <= r_next_addr + 32'd2;
              end else begin
                r_state <= ACCEPT;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = w_ready;
  assign avm_write     = (r_state == WRITE);
  assign busy          = (r_state != IDLE);
  assign avm_address   = r_avm_address;
  assign avm_writedata = r_avm_writedata;
  assign frame_done    = r_frame_done;

endmodule
